// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encodings, forwarding selects and register constants for the hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;
    localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: stage decode bundle into the controller and stall/flush/forward controls back out.
interface pipe_hazard_ctrl_if;
    logic [4:0]  d_rs1, d_rs2;
    logic        d_use_rs1, d_use_rs2;
    logic [4:0]  x_rs1, x_rs2, x_rd;
    logic        x_wb, x_is_load, x_redirect;
    logic [4:0]  m_rd;
    logic        m_wb, m_mem_req, dmem_ready;
    logic [4:0]  w_rd;
    logic        w_wb, w_ecall;
    logic        stall_f, stall_d, stall_x, stall_m;
    logic        flush_d, flush_x, flush_w;
    logic        pc_redirect;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        halted, mem_timeout;
    logic [1:0]  state;
    logic [31:0] perf_loaduse, perf_redirect, perf_memwait;
    modport master (
        output d_rs1, d_rs2, d_use_rs1, d_use_rs2, x_rs1, x_rs2, x_rd, x_wb, x_is_load,
               x_redirect, m_rd, m_wb, m_mem_req, dmem_ready, w_rd, w_wb, w_ecall,
        input  stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, flush_w, pc_redirect,
               fwd_a_sel, fwd_b_sel, halted, mem_timeout, state,
               perf_loaduse, perf_redirect, perf_memwait
    );
    modport slave (
        input  d_rs1, d_rs2, d_use_rs1, d_use_rs2, x_rs1, x_rs2, x_rd, x_wb, x_is_load,
               x_redirect, m_rd, m_wb, m_mem_req, dmem_ready, w_rd, w_wb, w_ecall,
        output stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, flush_w, pc_redirect,
               fwd_a_sel, fwd_b_sel, halted, mem_timeout, state,
               perf_loaduse, perf_redirect, perf_memwait
    );
endinterface

// File: rtl/fwd_sel.sv
// fwd_sel: picks the X operand source for one register index; M beats W, x0 never forwards.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] m_rd,
    input  logic       m_wb,
    input  logic [4:0] w_rd,
    input  logic       w_wb,
    output logic [1:0] sel
);
    always_comb sel = (src == REG_X0)           ? FWD_RF :
                      (m_wb && m_rd == src)     ? FWD_M  :
                      (w_wb && w_rd == src)     ? FWD_W  : FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect/forwarding sequencer for the 5-stage RV32I pipeline.
// Define PIPE_HAZARD_PERF_EN to enable the load-use/redirect/memory-wait cycle counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            halted_q, halted_d;
    logic            mem_timeout_q, mem_timeout_d;
    logic            halt_s, run_s, mw, lu, mw_act, rd_act, lu_act;
    logic [1:0]      fa, fb;

    fwd_sel u_fwd_a (.src(bus.x_rs1), .m_rd(bus.m_rd), .m_wb(bus.m_wb), .w_rd(bus.w_rd), .w_wb(bus.w_wb), .sel(fa));
    fwd_sel u_fwd_b (.src(bus.x_rs2), .m_rd(bus.m_rd), .m_wb(bus.m_wb), .w_rd(bus.w_rd), .w_wb(bus.w_wb), .sel(fb));

    // Encoding 3 is unreachable but must still behave as HALT, hence the MSB test.
    always_comb begin
        halt_s = state_q[1];
        run_s  = state_q == RUN;
        mw     = bus.m_mem_req & ~bus.dmem_ready;
        lu     = bus.x_is_load & bus.x_wb & (bus.x_rd != REG_X0) &
                 ((bus.d_use_rs1 & (bus.d_rs1 == bus.x_rd)) | (bus.d_use_rs2 & (bus.d_rs2 == bus.x_rd)));
        mw_act = ~halt_s & mw;
        rd_act = run_s & ~mw & bus.x_redirect;
        lu_act = run_s & ~mw & ~bus.x_redirect & lu;
    end

    // The release cycle out of MEM_WAIT only lets M complete; a frozen redirect fires once back in RUN.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        halted_d      = halted_q;
        mem_timeout_d = mem_timeout_q;
        if (!halt_s) begin
            if (bus.w_ecall) begin
                state_d  = HALT;
                halted_d = 1'b1;
            end else if (run_s) begin
                state_d = mw ? MEM_WAIT : RUN;
                cnt_d   = mw ? TO_W'(1) : '0;
            end else if (!mw) begin
                state_d = RUN;
                cnt_d   = '0;
            end else if (cnt_q == TO_MAX) begin
                state_d       = HALT;
                halted_d      = 1'b1;
                mem_timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            halted_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            halted_q      <= halted_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign bus.stall_f     = rst_n & (halt_s | mw_act | lu_act);
    assign bus.stall_d     = rst_n & (halt_s | mw_act | lu_act);
    assign bus.stall_x     = rst_n & (halt_s | mw_act);
    assign bus.stall_m     = rst_n & (halt_s | mw_act);
    assign bus.flush_d     = ~rst_n | rd_act;
    assign bus.flush_x     = ~rst_n | rd_act | lu_act;
    assign bus.flush_w     = ~rst_n | halt_s | mw_act;
    assign bus.pc_redirect = rst_n & rd_act;
    assign bus.fwd_a_sel   = rst_n ? fa : FWD_RF;
    assign bus.fwd_b_sel   = rst_n ? fb : FWD_RF;
    assign bus.halted      = halted_q;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.state       = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_lu_q, perf_lu_d, perf_rd_q, perf_rd_d, perf_mw_q, perf_mw_d;
    // The *_act terms are already zero in HALT, so the counters freeze there on their own.
    always_comb begin
        perf_lu_d = perf_lu_q + {31'd0, lu_act};
        perf_rd_d = perf_rd_q + {31'd0, rd_act};
        perf_mw_d = perf_mw_q + {31'd0, mw_act};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q <= '0;
            perf_rd_q <= '0;
            perf_mw_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_rd_q <= perf_rd_d;
            perf_mw_q <= perf_mw_d;
        end
    end
    assign bus.perf_loaduse  = perf_lu_q;
    assign bus.perf_redirect = perf_rd_q;
    assign bus.perf_memwait  = perf_mw_q;
`else
    assign bus.perf_loaduse  = '0;
    assign bus.perf_redirect = '0;
    assign bus.perf_memwait  = '0;
`endif
endmodule
